// File: rtl/core_if_fetch_if.sv
// Fetch-unit bundle: commit redirect, instruction-memory request/response, IFU delivery.
// master = fetch unit; slave = memory, commit and IFU side.
interface core_if_fetch_if #(
    parameter int PC_WIDTH   = 32,
    parameter int INST_WIDTH = 32
);
    logic                  i_pipe_flush_req;
    logic [PC_WIDTH-1:0]   i_flush_pc;
    logic                  o_req_valid;
    logic                  i_req_ready;
    logic [PC_WIDTH-1:0]   o_req_addr;
    logic                  i_rsp_valid;
    logic [INST_WIDTH-1:0] i_rsp_data;
    logic                  i_rsp_err;
    logic                  o_valid;
    logic                  i_ready;
    logic [INST_WIDTH-1:0] o_inst;
    logic [PC_WIDTH-1:0]   o_pc;
    logic                  o_err;

    modport master (
        input  i_pipe_flush_req, i_flush_pc, i_req_ready,
        input  i_rsp_valid, i_rsp_data, i_rsp_err, i_ready,
        output o_req_valid, o_req_addr, o_valid, o_inst, o_pc, o_err
    );

    modport slave (
        output i_pipe_flush_req, i_flush_pc, i_req_ready,
        output i_rsp_valid, i_rsp_data, i_rsp_err, i_ready,
        input  o_req_valid, o_req_addr, o_valid, o_inst, o_pc, o_err
    );
endinterface

// File: rtl/core_if_fetch.sv
// Fetch front end: issues word fetches (<=2 in flight), queues responses; request to o_valid in 2 cycles.
// Backpressure: a request is offered only when in-flight plus buffered, minus this cycle's pop, is below 2.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         wr_vld,
    input  logic [WIDTH-1:0]             wr_dat,
    input  logic                         rd_vld,
    output logic [WIDTH-1:0]             rd_dat,
    output logic [$clog2(DEPTH+1)-1:0]   cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        ptr_inc = (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Callers guarantee no write when full and no read when empty.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (wr_vld) begin
                mem_d[wr_ptr_q] = wr_dat;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (rd_vld) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            cnt_d = cnt_q + CW'(wr_vld) - CW'(rd_vld);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign rd_dat = mem_q[rd_ptr_q];
    assign cnt    = cnt_q;
endmodule

module core_if_fetch #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    core_if_fetch_if.master bus
);
    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [PC_WIDTH-1:0]   pc;
        logic                  err;
    } meta_t;

    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]          drop_q, drop_d;
    logic [1:0]          inflight;
    logic [1:0]          cnt;
    logic [2:0]          credit_used;
    logic [PC_WIDTH-1:0] pcq_head;
    meta_t               wr_ent;
    meta_t               head;
    logic                flush, pop, req_fire, rsp_acc, rsp_keep;

    assign flush       = bus.i_pipe_flush_req;
    assign pop         = bus.o_valid & bus.i_ready;
    assign credit_used = {1'b0, inflight} + {1'b0, cnt} - {2'b00, pop};

    // i_ready reaches o_req_valid combinationally so a full pipe still fetches every cycle.
    assign bus.o_req_valid = rst_n & ~flush & (credit_used < 3'd2);
    assign bus.o_req_addr  = fetch_pc_q;

    assign req_fire = bus.o_req_valid & bus.i_req_ready;
    assign rsp_acc  = bus.i_rsp_valid & (inflight != 2'd0);
    assign rsp_keep = rsp_acc & (drop_q == 2'd0);

    // PC queue: its occupancy is the in-flight count, kept across flushes so stale
    // responses still retire their PC entry.
    fifo #(.WIDTH(PC_WIDTH), .DEPTH(2)) u_pcq (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (1'b0),
        .wr_vld (req_fire),
        .wr_dat (fetch_pc_q),
        .rd_vld (rsp_acc),
        .rd_dat (pcq_head),
        .cnt    (inflight)
    );

    assign wr_ent = '{inst: bus.i_rsp_data, pc: pcq_head, err: bus.i_rsp_err};

    fifo #(.WIDTH($bits(meta_t)), .DEPTH(2)) u_instq (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (flush),
        .wr_vld (rsp_keep),
        .wr_dat (wr_ent),
        .rd_vld (pop),
        .rd_dat (head),
        .cnt    (cnt)
    );

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        drop_d     = drop_q;
        if (flush) begin
            fetch_pc_d = bus.i_flush_pc;
            drop_d     = inflight - {1'b0, rsp_acc};
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
            end
            if (rsp_acc && (drop_q != 2'd0)) begin
                drop_d = drop_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            drop_q     <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.o_valid = (cnt != 2'd0);
    assign bus.o_inst  = head.inst;
    assign bus.o_pc    = head.pc;
    assign bus.o_err   = head.err;
endmodule
